// File: rtl/rr_arbiter_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: handshake types,
// channel-count limits and the output-stage load rule.
package rr_arbiter_mux_pkg;

    localparam int CHANNELS_MIN = 2;
    localparam int CHANNELS_MAX = 32;

    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    // A one-entry stage may take new data when empty or when its content leaves this cycle.
    function automatic logic hs_can_load(input hs_t stage);
        return (~stage.valid) | stage.ready;
    endfunction

endpackage

// File: rtl/rr_arbiter_mux_picker.sv
// Combinational round-robin picker: finds the first requester after last_grant,
// wrapping modulo CHANNELS (works for non-power-of-2 counts).
module rr_priority_picker #(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last_grant,
    output logic [SEL_W-1:0]    grant,
    output logic                any
);

    localparam int IDX_W = SEL_W + 1;

    logic [2*CHANNELS-1:0] dbl_s;
    logic [CHANNELS-1:0]   rot_s;
    logic [IDX_W-1:0]      start_s;
    logic [IDX_W-1:0]      offset_s;
    logic [IDX_W-1:0]      sum_s;

    // Rotate so the channel after last_grant sits at bit 0, then pick the lowest set bit.
    always_comb begin
        start_s  = {1'b0, last_grant} + {{SEL_W{1'b0}}, 1'b1};
        dbl_s    = {req, req};
        rot_s    = dbl_s[start_s +: CHANNELS];
        offset_s = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                offset_s = IDX_W'(i);
            end else begin
                offset_s = offset_s;
            end
        end
        sum_s = start_s + offset_s;
        if (sum_s >= IDX_W'(CHANNELS)) begin
            grant = SEL_W'(sum_s - IDX_W'(CHANNELS));
        end else begin
            grant = SEL_W'(sum_s);
        end
        any = |rot_s;
    end

endmodule

// File: rtl/rr_arbiter_mux.sv
// N:1 valid/ready stream multiplexer with round-robin (or forced) channel
// selection and a one-entry registered output stage.
module rr_arbiter_mux
    import rr_arbiter_mux_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    input  logic                      out_ready
);

    logic                out_valid_r;
    logic [WIDTH-1:0]    out_data_r;
    logic [SEL_W-1:0]    out_channel_r;
    logic [SEL_W-1:0]    last_grant_r;

    logic [CHANNELS-1:0] force_mask_s;
    logic [CHANNELS-1:0] cand_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic [SEL_W-1:0]    grant_s;
    logic                any_s;
    logic                load_s;
    hs_t                 out_hs_s;
    logic [WIDTH-1:0]    sel_data_s;

    // Candidate masking; an out-of-range force_sel shifts the one-hot out and empties the set.
    always_comb begin
        force_mask_s = {{(CHANNELS-1){1'b0}}, 1'b1} << force_sel;
        if (force_en) begin
            cand_s = in_valid & force_mask_s;
        end else begin
            cand_s = in_valid;
        end
    end

    rr_priority_picker #(
        .CHANNELS (CHANNELS)
    ) u_picker (
        .req        (cand_s),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .any        (any_s)
    );

    // Ready decode and data select; ready is held low throughout reset.
    always_comb begin
        out_hs_s   = '{valid: out_valid_r, ready: out_ready};
        load_s     = hs_can_load(out_hs_s);
        in_ready_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready_s[i] = rst_n & load_s & any_s & (grant_s == SEL_W'(i));
        end
        sel_data_s = in_data[grant_s*WIDTH +: WIDTH];
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_channel_r <= '0;
            last_grant_r  <= SEL_W'(CHANNELS - 1);
        end else if (load_s) begin
            if (any_s) begin
                out_valid_r   <= 1'b1;
                out_data_r    <= sel_data_s;
                out_channel_r <= grant_s;
                last_grant_r  <= grant_s;
            end else begin
                out_valid_r   <= 1'b0;
            end
        end else begin
            out_valid_r   <= out_valid_r;
            out_data_r    <= out_data_r;
            out_channel_r <= out_channel_r;
            last_grant_r  <= last_grant_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_channel = out_channel_r;

endmodule
